// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared LEGv8 pipeline constants and hazard FSM state encoding
package pipe_pkg;

  localparam int REG_AW   = 5;
  localparam int ZERO_REG = 31;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } haz_state_t;

  localparam logic [10:0] OP_LDUR    = 11'b111_1100_0010;
  localparam logic [10:0] OP_STUR    = 11'b111_1100_0000;
  localparam logic [7:0]  OP_CBZ_PFX = 8'b1011_0100;

  function automatic logic is_cbz(input logic [10:0] opcode);
    return opcode[10:3] == OP_CBZ_PFX;
  endfunction

endpackage

// File: rtl/haz_timeout_cnt.sv
// rtl/haz_timeout_cnt.sv - data-memory wait counter with timeout compare and sticky error
module haz_timeout_cnt
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in_wait,
  input  logic i_mem_stall,
  input  logic i_dmem_ready,
  output logic o_hit,
  output logic o_err
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_err;

  assign w_cnt_inc = r_cnt + 1'b1;
  // Trap on the edge where the count reaches TIMEOUT-1: the RUN cycle that first
  // saw the wait plus TIMEOUT-1 WAIT cycles gives TIMEOUT frozen cycles in total.
  assign o_hit = i_in_wait & i_mem_stall & (w_cnt_inc == CNT_W'(TIMEOUT - 1));
  assign o_err = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_in_wait) begin
      r_cnt <= '0;
    end else if (!i_dmem_ready) begin
      r_cnt <= w_cnt_inc;
    end

    if (i_rst) begin
      r_err <= 1'b0;
    end else if (o_hit) begin
      r_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - LEGv8 5-stage hazard controller: load-use stall, branch flush, dmem wait/timeout
// Optional perf counters (stall/flush) are enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = pipe_pkg::REG_AW,
  parameter int ZERO_REG = pipe_pkg::ZERO_REG,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [REG_AW-1:0] i_id_rn,
  input  logic [REG_AW-1:0] i_id_rm,
  input  logic              i_id_rn_used,
  input  logic              i_id_rm_used,
  input  logic              i_ex_memread,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_mem_br_taken,
  input  logic              i_dmem_req,
  input  logic              i_dmem_ready,
  output logic              o_pc_we,
  output logic              o_ifid_we,
  output logic              o_ifid_flush,
  output logic              o_idex_flush,
  output logic              o_exmem_flush,
  output logic              o_pipe_freeze,
`ifdef HAZ_PERF_CNT_EN
  output logic              o_mem_timeout,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
`else
  output logic              o_mem_timeout
`endif
);

  import pipe_pkg::*;

  haz_state_t r_state;
  haz_state_t w_next_state;
  logic       w_mem_stall;
  logic       w_load_use;
  logic       w_hit;
  logic       w_err;

  assign w_mem_stall = i_dmem_req & ~i_dmem_ready;
  assign w_load_use  = i_ex_memread && (i_ex_rd != REG_AW'(ZERO_REG)) &&
                       ((i_id_rn_used && (i_id_rn == i_ex_rd)) ||
                        (i_id_rm_used && (i_id_rm == i_ex_rd)));

  haz_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_in_wait    (r_state == ST_WAIT),
    .i_mem_stall  (w_mem_stall),
    .i_dmem_ready (i_dmem_ready),
    .o_hit        (w_hit),
    .o_err        (w_err)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:  if (w_mem_stall) w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (w_hit) w_next_state = ST_ERR;
        else if (!w_mem_stall) w_next_state = ST_RUN;
      end
      ST_ERR:  w_next_state = ST_ERR;
      default: w_next_state = ST_RUN;
    endcase
  end

  // Priority: reset, error trap, memory freeze, branch flush, load-use bubble.
  always_comb begin
    o_pc_we       = 1'b1;
    o_ifid_we     = 1'b1;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    o_pipe_freeze = 1'b0;
    o_mem_timeout = 1'b0;
    if (i_rst) begin
      o_pc_we       = 1'b0;
      o_ifid_we     = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
    end else if (r_state == ST_ERR) begin
      o_pc_we       = 1'b0;
      o_ifid_we     = 1'b0;
      o_pipe_freeze = 1'b1;
      o_mem_timeout = w_err;
    end else if (w_mem_stall) begin
      o_pc_we       = 1'b0;
      o_ifid_we     = 1'b0;
      o_pipe_freeze = 1'b1;
    end else if (i_mem_br_taken) begin
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
    end else if (w_load_use) begin
      o_pc_we       = 1'b0;
      o_ifid_we     = 1'b0;
      o_idex_flush  = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic             w_active;
  logic             w_stall_evt;
  logic             w_flush_evt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  assign w_active    = ~i_rst & (r_state != ST_ERR);
  assign w_stall_evt = w_active & (w_mem_stall | (~i_mem_br_taken & w_load_use));
  assign w_flush_evt = w_active & ~w_mem_stall & i_mem_br_taken;
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_evt && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
`endif

endmodule
